// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: state encoding and transfer-target constants shared by the
// SPI transfer scheduler and its testbench.
package spi_sched_pkg;

    // Scheduler FSM states. IDLE is zero so a cleared debug bus reads as idle.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AMP_GO   = 3'd1,
        AMP_WAIT = 3'd2,
        ADC_GO   = 3'd3,
        ADC_WAIT = 3'd4
    } state_e;

    // Values driven on spi_sel for each transfer target.
    localparam logic SEL_AMP = 1'b0;
    localparam logic SEL_ADC = 1'b1;

    // True in the states that wait for spi_done from the SPI engine.
    function automatic logic is_wait(input state_e s);
        return (s == AMP_WAIT) || (s == ADC_WAIT);
    endfunction

endpackage

// File: rtl/spi_sched_tick.sv
// spi_sched_tick: free-running sample divider. While run_i is high it counts
// 0..SAMPLE_DIV-1, raises tick_o for the cycle holding the last count, then
// wraps. While run_i is low the count is held at zero, so the first tick after
// enabling always lands SAMPLE_DIV cycles later.
module spi_sched_tick #(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned DIV_W      = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == LAST);

    // Next count: clear when stopped or at the wrap point, else increment.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sched.sv
// spi_sched: schedules SPI transfers between an amplifier gain register and
// an ADC. Gain writes (requested by pulse, last value wins) take priority over
// periodic ADC samples produced by the spi_sched_tick divider. One transfer is
// in flight at a time; spi_sel is held from spi_go until spi_done.
//
// Valid/ready: spi_go is a one-cycle start pulse; the engine answers with a
// one-cycle spi_done, which is only honoured in AMP_WAIT/ADC_WAIT.
//
// Optional feature: define SPI_SCHED_TIMEOUT_EN to abort a transfer whose
// spi_done has not arrived within TIMEOUT cycles (err pulse, gain retried,
// sample discarded). Without it err_o is tied low and no counter is built.
module spi_sched #(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned DIV_W      = 16,
    parameter logic [7:0]  GAIN_RST   = 8'h11,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       gain_req_i,
    input  logic [7:0] gain_val_i,
    input  logic       spi_done_i,
    output logic       spi_go_o,
    output logic       spi_sel_o,
    output logic [7:0] spi_gain_o,
    output logic       amp_ready_o,
    output logic       sample_strobe_o,
    output logic       overrun_o,
    output logic       err_o,
    output logic [2:0] state_dbg_o
);

    import spi_sched_pkg::*;

    state_e     state_q, state_d;
    logic       gain_pend_q, gain_pend_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] spi_gain_q, spi_gain_d;
    logic       sel_q, sel_d;
    logic       amp_ready_q, amp_ready_d;
    logic       strobe_q, strobe_d;
    logic       tick_pend_q, tick_pend_d;
    logic       overrun_q, overrun_d;
    logic       tick;
    logic       tmo_hit;

    spi_sched_tick #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .DIV_W      (DIV_W)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .run_i  (en_i && amp_ready_q),
        .tick_o (tick)
    );

    // Start pulse is a pure function of state: one cycle per GO state.
    assign spi_go_o        = (state_q == AMP_GO) || (state_q == ADC_GO);
    assign spi_sel_o       = sel_q;
    // During AMP_GO the word about to be loaded is already on the bus, so the
    // engine sees the correct gain together with spi_go.
    assign spi_gain_o      = (state_q == AMP_GO) ? shadow_q : spi_gain_q;
    assign amp_ready_o     = amp_ready_q;
    assign sample_strobe_o = strobe_q;
    assign overrun_o       = overrun_q;
    assign state_dbg_o     = state_q;

    // Next-state logic, pending-request bookkeeping and transfer side effects.
    always_comb begin
        state_d     = state_q;
        gain_pend_d = gain_pend_q;
        shadow_d    = shadow_q;
        spi_gain_d  = spi_gain_q;
        sel_d       = sel_q;
        amp_ready_d = amp_ready_q;
        strobe_d    = 1'b0;
        tick_pend_d = tick_pend_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                if (gain_pend_q) begin
                    state_d = AMP_GO;
                end else if (tick_pend_q && amp_ready_q && en_i) begin
                    state_d = ADC_GO;
                end
            end
            AMP_GO: begin
                spi_gain_d  = shadow_q;
                gain_pend_d = 1'b0;
                state_d     = AMP_WAIT;
            end
            AMP_WAIT: begin
                if (spi_done_i) begin
                    amp_ready_d = 1'b1;
                    state_d     = IDLE;
                end else if (tmo_hit) begin
                    gain_pend_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            ADC_GO: begin
                tick_pend_d = 1'b0;
                state_d     = ADC_WAIT;
            end
            ADC_WAIT: begin
                if (spi_done_i) begin
                    strobe_d = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new request always lands, even in the cycle AMP_GO consumes the
        // previous one, so it is applied after the state actions.
        if (gain_req_i) begin
            shadow_d    = gain_val_i;
            gain_pend_d = 1'b1;
        end

        // A tick arriving while one is still queued is lost, except in ADC_GO
        // where the queued one is being taken right now.
        if (tick) begin
            if (tick_pend_q && (state_q != ADC_GO)) begin
                overrun_d = 1'b1;
            end
            tick_pend_d = 1'b1;
        end

        // Sampling disabled: forget queued samples and the overrun history.
        if (!en_i) begin
            tick_pend_d = 1'b0;
            overrun_d   = 1'b0;
        end

        // Target select is captured on entry to a GO state and held after.
        if (state_d == AMP_GO) begin
            sel_d = SEL_AMP;
        end else if (state_d == ADC_GO) begin
            sel_d = SEL_ADC;
        end
    end

    // State and datapath registers; reset queues the automatic gain write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            gain_pend_q <= 1'b1;
            shadow_q    <= GAIN_RST;
            spi_gain_q  <= GAIN_RST;
            sel_q       <= SEL_AMP;
            amp_ready_q <= 1'b0;
            strobe_q    <= 1'b0;
            tick_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_pend_q <= gain_pend_d;
            shadow_q    <= shadow_d;
            spi_gain_q  <= spi_gain_d;
            sel_q       <= sel_d;
            amp_ready_q <= amp_ready_d;
            strobe_q    <= strobe_d;
            tick_pend_q <= tick_pend_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             in_wait;

    assign in_wait = is_wait(state_q);
    assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign err_o   = err_q;

    // Count cycles spent waiting; restarts from zero for every transfer.
    always_comb begin
        tmo_d = '0;
        err_d = tmo_hit && !spi_done_i;
        if (in_wait && !tmo_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter and error pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

endmodule
